// File: rtl/yin_pkg.sv
// Shared widths, FSM encoding and Q-format helper for the YIN pitch pipeline stages.
package yin_pkg;

   function automatic int unsigned tau_w(input int unsigned max_tau);
      return $clog2(max_tau + 1);
   endfunction

   function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned max_tau);
      return data_w + tau_w(max_tau);
   endfunction

   function automatic int unsigned num_w(input int unsigned data_w, input int unsigned max_tau,
                                         input int unsigned frac_bits);
      return data_w + tau_w(max_tau) + frac_bits;
   endfunction

   // Q-format unity: ONE = 1 << frac_bits
   function automatic longint unsigned one_q(input int unsigned frac_bits);
      return 64'd1 << frac_bits;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DIV,
      ST_OUT,
      ST_UPD,
      ST_DONE
   } cmndf_state_e;

endpackage

// File: rtl/yin_cmndf_stream_module_div.sv
// Unsigned restoring divider, one quotient bit per cycle; done is held high until the next start.
module seq_divider_module #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned Q_WIDTH = WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               done,
   output logic [Q_WIDTH-1:0] quotient
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   // quo_q shifts dividend bits out at the top while quotient bits enter at the bottom
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   trial;

   always_comb begin
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = done_q;
      trial  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      if (start) begin
         quo_d  = dividend;
         rem_d  = '0;
         dvs_d  = divisor;
         cnt_d  = CNT_W'(WIDTH);
         busy_d = 1'b1;
         done_d = 1'b0;
      end else if (busy_q) begin
         if (trial >= {1'b0, dvs_q}) begin
            rem_d = trial - {1'b0, dvs_q};
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = trial;
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign done     = done_q;
   assign quotient = quo_q[Q_WIDTH-1:0];

endmodule

// File: rtl/yin_cmndf_stream_module.sv
// Streaming CMNDF stage d'(tau) = d(tau)*tau / sum d(1..tau) with YIN absolute-threshold search.
// Optional per-lag output stream: define CMNDF_STREAM_OUT_EN.
module yin_cmndf_stream_module
   import yin_pkg::*;
#(
   parameter int unsigned  DATA_WIDTH = 32,
   parameter int unsigned  MAX_TAU    = 40,
   parameter int unsigned  FRAC_BITS  = 12,
   parameter int unsigned  THRESHOLD  = 410,
   localparam int unsigned TAU_W      = tau_w(MAX_TAU),
   localparam int unsigned OUT_W      = FRAC_BITS + TAU_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
`ifdef CMNDF_STREAM_OUT_EN
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_W-1:0]      out_data,
   output logic [TAU_W-1:0]      out_tau,
`endif
   output logic                  pitch_valid,
   output logic [TAU_W-1:0]      pitch_tau,
   output logic                  pitch_found
);
   localparam int unsigned      SUM_W     = sum_w(DATA_WIDTH, MAX_TAU);
   localparam int unsigned      NUM_W     = num_w(DATA_WIDTH, MAX_TAU, FRAC_BITS);
   localparam logic [OUT_W-1:0] ONE       = OUT_W'(one_q(FRAC_BITS));
   localparam logic [OUT_W-1:0] THR       = OUT_W'(THRESHOLD);
   localparam logic [TAU_W-1:0] TAU_FIRST = TAU_W'(1);
   localparam logic [TAU_W-1:0] TAU_LAST  = TAU_W'(MAX_TAU);

   cmndf_state_e     state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic [TAU_W-1:0] tau_q, tau_d;
   logic [SUM_W-1:0] cumsum_q, cumsum_d;
   logic             zero_q, zero_d;
   logic [OUT_W-1:0] dq_q, dq_d;
   logic             below_q, below_d;
   logic             locked_q, locked_d;
   logic [TAU_W-1:0] best_tau_q, best_tau_d;
   logic [OUT_W-1:0] best_val_q, best_val_d;
   logic             pitch_valid_q, pitch_valid_d;
   logic [TAU_W-1:0] pitch_tau_q, pitch_tau_d;
   logic             pitch_found_q, pitch_found_d;
`ifdef CMNDF_STREAM_OUT_EN
   logic [TAU_W-1:0] out_tau_q, out_tau_d;
`endif

   logic             hs;
   logic [SUM_W-1:0] cum_new;
   logic [NUM_W-1:0] numer;
   logic [NUM_W-1:0] denom;
   logic             div_start;
   logic             div_done;
   logic [OUT_W-1:0] div_quot;

   // in_ready_q tracks IDLE but is held low through reset, so it rises one cycle after release
   assign hs        = in_valid & in_ready_q;
   assign cum_new   = cumsum_q + SUM_W'(in_data);
   assign numer     = (NUM_W'(in_data) * NUM_W'(tau_q)) << FRAC_BITS;
   assign denom     = NUM_W'(cum_new);
   assign div_start = hs & (cum_new != '0);

   seq_divider_module #(
      .WIDTH   (NUM_W),
      .Q_WIDTH (OUT_W)
   ) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .dividend (numer),
      .divisor  (denom),
      .done     (div_done),
      .quotient (div_quot)
   );

   always_comb begin
      state_d       = state_q;
      tau_d         = tau_q;
      cumsum_d      = cumsum_q;
      zero_d        = zero_q;
      dq_d          = dq_q;
      below_d       = below_q;
      locked_d      = locked_q;
      best_tau_d    = best_tau_q;
      best_val_d    = best_val_q;
      pitch_valid_d = 1'b0;
      pitch_tau_d   = pitch_tau_q;
      pitch_found_d = pitch_found_q;
`ifdef CMNDF_STREAM_OUT_EN
      out_tau_d     = out_tau_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               cumsum_d = cum_new;
               zero_d   = (cum_new == '0);
               state_d  = ST_DIV;
            end
         end
         ST_DIV: begin
            if (zero_q || div_done) begin
               dq_d = zero_q ? ONE : div_quot;
`ifdef CMNDF_STREAM_OUT_EN
               out_tau_d = tau_q;
               state_d   = ST_OUT;
`else
               state_d   = ST_UPD;
`endif
            end
         end
`ifdef CMNDF_STREAM_OUT_EN
         ST_OUT: begin
            if (out_ready) state_d = ST_UPD;
         end
`endif
         ST_UPD: begin
            if (!below_q) begin
               if (dq_q < THR) begin
                  below_d    = 1'b1;
                  best_tau_d = tau_q;
                  best_val_d = dq_q;
               end else if (dq_q < best_val_q) begin
                  best_tau_d = tau_q;
                  best_val_d = dq_q;
               end
            end else if (!locked_q) begin
               if (dq_q < best_val_q) begin
                  best_tau_d = tau_q;
                  best_val_d = dq_q;
               end else begin
                  locked_d = 1'b1;
               end
            end
            if (tau_q == TAU_LAST) begin
               pitch_valid_d = 1'b1;
               pitch_tau_d   = best_tau_d;
               pitch_found_d = below_d;
               state_d       = ST_DONE;
            end else begin
               tau_d   = tau_q + 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            tau_d      = TAU_FIRST;
            cumsum_d   = '0;
            below_d    = 1'b0;
            locked_d   = 1'b0;
            best_tau_d = TAU_FIRST;
            best_val_d = '1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         in_ready_q    <= 1'b0;
         tau_q         <= TAU_FIRST;
         cumsum_q      <= '0;
         zero_q        <= 1'b0;
         dq_q          <= '0;
         below_q       <= 1'b0;
         locked_q      <= 1'b0;
         best_tau_q    <= TAU_FIRST;
         best_val_q    <= '1;
         pitch_valid_q <= 1'b0;
         pitch_tau_q   <= '0;
         pitch_found_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         in_ready_q    <= in_ready_d;
         tau_q         <= tau_d;
         cumsum_q      <= cumsum_d;
         zero_q        <= zero_d;
         dq_q          <= dq_d;
         below_q       <= below_d;
         locked_q      <= locked_d;
         best_tau_q    <= best_tau_d;
         best_val_q    <= best_val_d;
         pitch_valid_q <= pitch_valid_d;
         pitch_tau_q   <= pitch_tau_d;
         pitch_found_q <= pitch_found_d;
      end
   end

`ifdef CMNDF_STREAM_OUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) out_tau_q <= '0;
      else        out_tau_q <= out_tau_d;
   end

   assign out_valid = (state_q == ST_OUT);
   assign out_data  = dq_q;
   assign out_tau   = out_tau_q;
`endif

   assign in_ready    = in_ready_q;
   assign pitch_valid = pitch_valid_q;
   assign pitch_tau   = pitch_tau_q;
   assign pitch_found = pitch_found_q;

endmodule
